pcie_us_msi_sched: RTL and testbench

PCIE_US_MSI_SCHED -- requirements
Module: pcie_us_msi_sched

---
 rtl/pcie_us_msi_sched.sv | 136 +++++++++++++
 tb/tb_pcie_us_msi_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_msi_sched.sv
// Round-robin MSI scheduler for the UltraScale PCIe core: pending vectors -> one-hot msi_int with sent/fail/timeout handling.
// Optional build macro MSI_FAIL_RETRY_EN: failed vectors stay pending and are retried after a backoff period.
module pcie_us_msi_sched #(
  parameter int IRQ_COUNT = 32,
  parameter int TIMEOUT   = 1024,
  parameter int BACKOFF   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  output logic [31:0]          cfg_interrupt_msi_int,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 busy,
  output logic [15:0]          stat_fail_count
);

  localparam int IW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BACKOFF + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_t;

  state_t               state_reg, state_next;
  logic [IRQ_COUNT-1:0] pending_reg, pending_next;
  logic [IW-1:0]        last_reg, win_reg, pick;
  logic [31:0]          msi_int_reg;
  logic [TW-1:0]        timer_reg;
  logic [BW-1:0]        bo_reg;
  logic [15:0]          fail_cnt_reg;

  logic [IRQ_COUNT-1:0] elig, above;
  logic [2:0]           mm_cap;
  logic                 any_above;
  logic                 take, done, fail_evt;
  logic                 unused_cfg;

  assign unused_cfg = &{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};
  assign mm_cap = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];

  // above[] marks indices after the last-served vector, where the rotating search begins
  generate
    for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_elig
      assign elig[gi]  = pending_reg[gi] & cfg_interrupt_msi_enable[0]
                         & (6'(gi) < (6'd1 << mm_cap));
      assign above[gi] = (IW+1)'(gi) > {1'b0, last_reg};
    end
    for (genvar gi = 0; gi < 32; gi++) begin : g_status
      if (gi < IRQ_COUNT) begin : g_used
        assign cfg_interrupt_msi_pending_status[gi] = pending_reg[gi];
      end else begin : g_zero
        assign cfg_interrupt_msi_pending_status[gi] = 1'b0;
      end
    end
  endgenerate

  assign any_above = |(elig & above);

  always_comb begin
    pick = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (any_above ? (elig[i] && above[i]) : elig[i]) pick = i[IW-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    done       = 1'b0;
    fail_evt   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|elig) begin
          take       = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (cfg_interrupt_msi_fail || timer_reg == TW'(TIMEOUT - 1)) begin
          fail_evt = 1'b1;
`ifdef MSI_FAIL_RETRY_EN
          state_next = S_BACKOFF;
`else
          done       = 1'b1;
          state_next = S_IDLE;
`endif
        end
      end
      S_BACKOFF: begin
        if (bo_reg == BW'(BACKOFF - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A fresh irq in the clearing cycle keeps the bit set
  always_comb begin
    pending_next = pending_reg;
    if (done) pending_next = pending_reg & ~(IRQ_COUNT'(1) << win_reg);
    pending_next = pending_next | irq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      pending_reg  <= '0;
      last_reg     <= IW'(IRQ_COUNT - 1);
      win_reg      <= '0;
      msi_int_reg  <= '0;
      timer_reg    <= '0;
      bo_reg       <= '0;
      fail_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      msi_int_reg <= take ? (32'd1 << pick) : 32'd0;
      timer_reg   <= (state_reg == S_WAIT) ? timer_reg + 1'b1 : '0;
      bo_reg      <= (state_reg == S_BACKOFF) ? bo_reg + 1'b1 : '0;
      if (take) win_reg <= pick;
      if (done) last_reg <= win_reg;
      if (fail_evt && fail_cnt_reg != 16'hFFFF) fail_cnt_reg <= fail_cnt_reg + 16'd1;
    end
  end

  assign cfg_interrupt_msi_int = msi_int_reg;
  assign busy                  = (state_reg != S_IDLE);
  assign stat_fail_count       = fail_cnt_reg;

endmodule

// File: tb/tb_pcie_us_msi_sched.sv
// Bench for pcie_us_msi_sched: directed scenarios plus random irq/config/response traffic against a transaction-level model.
module tb_pcie_us_msi_sched;

  localparam int N  = 32;
  localparam int TO = 1024;
  localparam int BO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq = '0;
  logic [3:0]  en = 4'h1;
  logic [11:0] mm = 12'd5;
  logic        sent = 1'b0;
  logic        fail = 1'b0;
  logic [31:0] msi_int;
  logic [31:0] pend_st;
  logic        busy;
  logic [15:0] fcnt;

  pcie_us_msi_sched #(.IRQ_COUNT(N), .TIMEOUT(TO), .BACKOFF(BO)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .irq                             (irq),
    .cfg_interrupt_msi_enable        (en),
    .cfg_interrupt_msi_mmenable      (mm),
    .cfg_interrupt_msi_int           (msi_int),
    .cfg_interrupt_msi_sent          (sent),
    .cfg_interrupt_msi_fail          (fail),
    .cfg_interrupt_msi_pending_status(pend_st),
    .busy                            (busy),
    .stat_fail_count                 (fcnt)
  );

  always #2 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // Reference model: pending set, who is outstanding, when the scheduler may arbitrate again
  bit [31:0] m_pend;
  int        m_last, m_win, m_issue_cyc, m_bo_end, m_fail;
  bit        m_out, m_issue;
  int        cyc;
  int        resp_cyc;
  bit        resp_fail;
  bit        auto_resp = 1'b0;
  int        fail_pct = 0;
  int        issued[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick();
    int lim;
    int mcap;
    int idx;
    mcap = (mm[2:0] > 3'd5) ? 5 : int'(mm[2:0]);
    lim = 1 << mcap;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (m_pend[idx] && en[0] && idx < lim) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_last = N - 1; m_win = 0; m_issue_cyc = 0;
    m_bo_end = -1; m_fail = 0; m_out = 0; m_issue = 0;
  endtask

  task automatic do_reset();
    irq = '0; sent = 0; fail = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_msi_int", msi_int, 32'd0);
    check_eq("rst_pending", pend_st, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_fail_cnt", {16'd0, fcnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    $display("[TB] reset released");
  endtask

  // One clock cycle: check visible outputs, drive inputs, advance the model
  task automatic cycle(input logic [31:0] irq_v, input logic s_v, input logic f_v);
    int  p;
    bit  s, f;
    bit  exp_busy;
    bit  fin;
    exp_busy = m_issue || m_out || (cyc <= m_bo_end);
    check_eq("msi_int", msi_int, m_issue ? (32'd1 << m_win) : 32'd0);
    check_eq("pending", pend_st, m_pend);
    check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
    check_eq("fail_cnt", {16'd0, fcnt}, m_fail);
    if (m_issue) begin
      issued.push_back(m_win);
      $display("[TB] cyc=%0d issue vector %0d", cyc, m_win);
      m_out = 1; m_issue_cyc = cyc;
      resp_cyc = cyc + 1 + $urandom_range(0, 5);
      resp_fail = ($urandom_range(0, 99) < fail_pct);
    end
    s = s_v; f = f_v;
    if (auto_resp && m_out && cyc == resp_cyc) begin
      s = !resp_fail;
      f = resp_fail || ($urandom_range(0, 3) == 0);
    end
    irq = irq_v; sent = s; fail = f;

    p = (!m_issue && !m_out && cyc > m_bo_end) ? rr_pick() : -1;
    m_issue = (p >= 0);
    if (p >= 0) m_win = p;
    fin = 0;
    if (m_out && cyc > m_issue_cyc) begin
      if (s) begin
        fin = 1; m_last = m_win; m_out = 0;
      end else if (f || cyc == m_issue_cyc + TO) begin
        if (m_fail < 65535) m_fail++;
        m_out = 0;
`ifdef MSI_FAIL_RETRY_EN
        m_bo_end = cyc + BO;
`else
        fin = 1; m_last = m_win;
`endif
      end
    end
    if (fin) m_pend[m_win] = 1'b0;
    m_pend = m_pend | irq_v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Single vector, fixed latency, sent clears pending
    do_reset();
    en = 4'h1; mm = 12'd5; auto_resp = 0;
    run(10);
    cycle(32'h8, 1'b0, 1'b0);
    check_eq("lat_c11", msi_int, 32'h0);
    cycle('0, 1'b0, 1'b0);
    check_eq("lat_c12", msi_int, 32'h8);
    cycle('0, 1'b0, 1'b0);
    check_eq("lat_c13", msi_int, 32'h0);
    run(2);
    cycle('0, 1'b1, 1'b0);
    check_eq("sent_pend", pend_st, 32'h0);
    check_eq("sent_busy", {31'd0, busy}, 32'd0);

    // Simultaneous requests served in round-robin order from vector 0
    do_reset();
    auto_resp = 1; fail_pct = 0; issued.delete();
    cycle(32'h8000_0021, 1'b0, 1'b0);
    run(40);
    check_eq("rr_count", issued.size(), 3);
    if (issued.size() == 3) begin
      check_eq("rr_first", issued[0], 0);
      check_eq("rr_second", issued[1], 5);
      check_eq("rr_third", issued[2], 31);
    end

    // Vectors above the multiple-message limit wait until the limit grows
    do_reset();
    mm = 12'd2; issued.delete();
    cycle(32'h12, 1'b0, 1'b0);
    run(30);
    check_eq("mm_count", issued.size(), 1);
    if (issued.size() >= 1) check_eq("mm_vec1", issued[0], 1);
    check_eq("mm_pend4", pend_st, 32'h10);
    mm = 12'd3;
    run(30);
    check_eq("mm_count2", issued.size(), 2);
    if (issued.size() >= 2) check_eq("mm_vec4", issued[1], 4);
    check_eq("mm_pend_clr", pend_st, 32'h0);

    // Explicit fail on vector 2
    do_reset();
    mm = 12'd5; auto_resp = 0;
    cycle(32'h4, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    check_eq("f_issue", msi_int, 32'h4);
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    check_eq("f_count", {16'd0, fcnt}, 32'd1);
    auto_resp = 1; fail_pct = 0; issued.delete();
    run(40);
`ifdef MSI_FAIL_RETRY_EN
    check_eq("f_reissue", issued.size(), 1);
    if (issued.size() == 1) check_eq("f_reissue_vec", issued[0], 2);
`else
    check_eq("f_no_reissue", issued.size(), 0);
`endif
    check_eq("f_pend", pend_st, 32'h0);

    // Timeout with no response at all
    do_reset();
    auto_resp = 0;
    cycle(32'h80, 1'b0, 1'b0);
    run(1100);
    check_eq("to_count", {16'd0, fcnt}, 32'd1);

    // Reset in the middle of a wait, then a stray sent
    do_reset();
    cycle(32'h200, 1'b0, 1'b0);
    run(3);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    do_reset();
    cycle('0, 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1);
    run(3);
    check_eq("late_busy", {31'd0, busy}, 32'd0);
    check_eq("late_fcnt", {16'd0, fcnt}, 32'd0);
    check_eq("late_pend", pend_st, 32'd0);

    // Random traffic, config churn and sent/fail mixes
    do_reset();
    auto_resp = 1; fail_pct = 15;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      r = '0;
      if ((i % 100) == 0) begin
        en = {3'($urandom), ($urandom_range(0, 3) != 0)};
        mm = 12'($urandom);
      end
      if ($urandom_range(0, 9) < 3) r[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      cycle(r, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
